d16_intc: RTL

Interrupt controller that schedules up to seven peripheral interrupt sources onto the d16 CPU's 3-bit interrupt input (i_int).
- Latches requests, applies per-source mask and edge/level mode, and picks the highest-priority pending source.
- Holds that source's ID on o_int until software writes End-Of-Interrupt (EOI), then forces a zero gap so the CPU's 0→nonzero detect re-arms.
- Appears as a 4-word Wishbone slave on the CPU data bus.

---
 rtl/d16_intc_pkg.sv | 26 ++
 rtl/d16_intc_prio.sv | 19 +
 rtl/d16_intc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/d16_intc_pkg.sv
// Shared constants, register offsets and FSM encoding for the d16 interrupt controller.
package d16_intc_pkg;

   localparam int NUM_SRC = 7;

   localparam logic [1:0] REG_PEND = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_MODE = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int BUSY_BIT  = 15;
   localparam int TFLAG_BIT = 14;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   // ID k+1 maps to request bit k; ID 0 means "no source".
   function automatic logic [NUM_SRC-1:0] id_to_onehot(input logic [2:0] id);
      id_to_onehot = '0;
      if (id != 3'd0) id_to_onehot[id - 3'd1] = 1'b1;
   endfunction

endpackage

// File: rtl/d16_intc_prio.sv
// Combinational 7->3 priority encoder: the highest set request bit wins (bit 6 = ID 7).
module d16_intc_prio
   import d16_intc_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   output logic [2:0]         id,
   output logic               valid
);

   always_comb begin
      id = 3'd0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (req[k]) id = 3'(k + 1);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/d16_intc.sv
// d16 interrupt controller: latches up to seven requests and presents one source ID to the CPU.
// Optional auto-EOI timeout is compiled in with D16_INTC_AUTOEOI_EN.
module d16_intc
   import d16_intc_pkg::*;
#(
   parameter logic [15:0] BASE       = 16'hFF00,
   parameter int          GAP_CYCLES = 1,
   parameter int          TIMEOUT    = 1024
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [6:0]  i_irq,
   input  logic [15:0] i_wb_addr,
   input  logic        i_wb_cyc,
   input  logic        i_wb_we,
   input  logic [15:0] i_wb_dat,
   output logic [15:0] o_wb_dat,
   output logic [2:0]  o_int,
   output logic [1:0]  o_dbg_state
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t             state, state_d;
   logic [NUM_SRC-1:0] pend, mask, mode, irq_q;
   logic [NUM_SRC-1:0] cand, set_vec, clr_vec;
   logic [2:0]         cur_id, win_id;
   logic               win_vld;
   logic [GW-1:0]      gap_cnt;
   logic               take, timeout_hit, tflag, busy;
   logic               sel, wr_pend, wr_mask, wr_mode, wr_ctrl, eoi;
   logic               unused_bits;

   // Bus handshake: no ack or stall. An access completes in any cycle where sel is high;
   // writes commit on that clock edge, reads are combinational with no side effects.
   assign sel     = i_wb_cyc && (i_wb_addr[15:2] == BASE[15:2]);
   assign wr_pend = sel && i_wb_we && (i_wb_addr[1:0] == REG_PEND);
   assign wr_mask = sel && i_wb_we && (i_wb_addr[1:0] == REG_MASK);
   assign wr_mode = sel && i_wb_we && (i_wb_addr[1:0] == REG_MODE);
   assign wr_ctrl = sel && i_wb_we && (i_wb_addr[1:0] == REG_CTRL);
   assign eoi     = wr_ctrl && (state == ACTIVE);

   assign cand = pend & mask;

   d16_intc_prio u_prio (
      .req   (cand),
      .id    (win_id),
      .valid (win_vld)
   );

`ifdef D16_INTC_AUTOEOI_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;

   // A software EOI on the same edge wins, so the flag is only raised for a true timeout.
   assign timeout_hit = (state == ACTIVE) && !eoi && (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         to_cnt <= '0;
         tflag  <= 1'b0;
      end else begin
         to_cnt <= (state == ACTIVE && state_d == ACTIVE) ? to_cnt + 1'b1 : '0;
         if (timeout_hit)  tflag <= 1'b1;
         else if (wr_ctrl) tflag <= 1'b0;
      end
   end

   assign unused_bits = ^i_wb_dat[15:7];
`else
   assign timeout_hit = 1'b0;
   assign tflag       = 1'b0;
   assign unused_bits = ^{i_wb_dat[15:7], 16'(TIMEOUT)};
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_d;
   end

   // The last gap cycle arbitrates directly so the zero gap lasts exactly GAP_CYCLES.
   always_comb begin
      state_d = state;
      take    = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               take    = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (eoi || timeout_hit) state_d = GAP;
         end
         GAP: begin
            if (gap_cnt == '0) begin
               if (win_vld) begin
                  take    = 1'b1;
                  state_d = ACTIVE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      o_int       = (state == ACTIVE) ? cur_id : 3'd0;
      o_dbg_state = state;
   end

   // Level sources re-set every cycle their line is high, so clears only stick once it drops.
   assign set_vec = i_irq & (~mode | ~irq_q);
   assign clr_vec = (wr_pend ? (i_wb_dat[6:0] & mode) : '0)
                  | (take ? id_to_onehot(win_id) : '0);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         pend    <= '0;
         mask    <= '0;
         mode    <= 7'h7F;
         irq_q   <= '0;
         cur_id  <= 3'd0;
         gap_cnt <= '0;
      end else begin
         irq_q <= i_irq;
         pend  <= (pend & ~clr_vec) | set_vec;
         if (wr_mask) mask <= i_wb_dat[6:0];
         if (wr_mode) mode <= i_wb_dat[6:0];
         if (take)    cur_id <= win_id;
         if (state == ACTIVE && state_d == GAP) gap_cnt <= GW'(GAP_CYCLES - 1);
         else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end
   end

   always_comb begin
      o_wb_dat = 16'h0000;
      if (sel) begin
         case (i_wb_addr[1:0])
            REG_PEND: o_wb_dat = {9'b0, pend};
            REG_MASK: o_wb_dat = {9'b0, mask};
            REG_MODE: o_wb_dat = {9'b0, mode};
            default: begin
               o_wb_dat[BUSY_BIT]  = busy;
               o_wb_dat[TFLAG_BIT] = tflag;
               o_wb_dat[2:0]       = cur_id;
            end
         endcase
      end
   end

endmodule
